// File: rtl/irq_pkg.sv
// +----------------------------------------------------------------------+
// | irq_pkg : shared types and constants for the interrupt arbiter        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package irq_pkg;

  localparam int NUM_SRC = 16;
  localparam int LVL_W   = 3;
  localparam int VEC_W   = 4;
  localparam int TMO_W   = 8;
  localparam int NUM_FLD = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Adjacent source pairs share one 3-bit priority field.
  function automatic logic [2:0] src_field(input logic [VEC_W-1:0] src);
    return src[3:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_tree.sv
// +----------------------------------------------------------------------+
// | irq_prio_tree : 16-input max-level finder, lowest index wins ties     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_prio_tree
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0]       cand,
  input  logic [NUM_SRC*LVL_W-1:0] lvl_flat,
  output logic                     valid,
  output logic [VEC_W-1:0]         vec,
  output logic [LVL_W-1:0]         lvl
);

  // Strict greater-than while scanning upward keeps the lowest index on ties;
  // candidates always carry a non-zero level so starting from 0 is safe.
  always_comb begin
    valid = |cand;
    vec   = '0;
    lvl   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (cand[s] && (lvl_flat[s*LVL_W +: LVL_W] > lvl)) begin
        vec = VEC_W'(s);
        lvl = lvl_flat[s*LVL_W +: LVL_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// +----------------------------------------------------------------------+
// | irq_arbiter : priority arbiter and req/ack/done service sequencer     |
// | Optional service timeout built when IRQ_ARB_TMO_EN is defined.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_arbiter
  import irq_pkg::*;
(
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [7:0]       isra,
  input  logic [7:0]       isrb,
  input  logic [7:0]       iera,
  input  logic [7:0]       ierb,
  input  logic [7:0]       ipra,
  input  logic [7:0]       iprb,
  input  logic [7:0]       iprc,
  input  logic [7:0]       iprd,
  input  logic [7:0]       syscr,
  input  logic [7:0]       tmo,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [LVL_W-1:0] irq_lvl,
  output logic             in_service,
  output logic             tmo_err
);

  logic [NUM_SRC-1:0]       pend;
  logic [NUM_SRC-1:0]       en;
  logic [NUM_SRC-1:0]       cand;
  logic [NUM_SRC*LVL_W-1:0] src_lvl;
  logic [LVL_W-1:0]         fld [NUM_FLD];

  logic                     win_valid;
  logic [VEC_W-1:0]         win_vec;
  logic [LVL_W-1:0]         win_lvl;
  logic                     expire;
  logic                     unused_bits;

  irq_state_e       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             req_q, req_d;
  logic             svc_q, svc_d;
  logic             err_q, err_d;

  assign pend = {isrb, isra};
  assign en   = {ierb, iera};

  assign fld[0] = ipra[2:0];
  assign fld[1] = ipra[6:4];
  assign fld[2] = iprb[2:0];
  assign fld[3] = iprb[6:4];
  assign fld[4] = iprc[2:0];
  assign fld[5] = iprc[6:4];
  assign fld[6] = iprd[2:0];
  assign fld[7] = iprd[6:4];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src_lvl[s*LVL_W +: LVL_W] = fld[src_field(VEC_W'(s))];
    assign cand[s] = pend[s] & en[s] & (|src_lvl[s*LVL_W +: LVL_W]);
  end

  irq_prio_tree u_prio_tree (
    .cand     (cand),
    .lvl_flat (src_lvl),
    .valid    (win_valid),
    .vec      (win_vec),
    .lvl      (win_lvl)
  );

`ifdef IRQ_ARB_TMO_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // A zero count means this service runs without a deadline.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == REQ && irq_ack) begin
      cnt_d = syscr[0] ? tmo : '0;
    end else if (state_q == SERVICE) begin
      if (irq_done || cnt_q <= TMO_W'(1)) cnt_d = '0;
      else                                cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign expire      = (state_q == SERVICE) && (cnt_q == TMO_W'(1));
  assign unused_bits = ^{syscr[7:1], ipra[7], ipra[3], iprb[7], iprb[3],
                         iprc[7], iprc[3], iprd[7], iprd[3]};
`else
  assign expire      = 1'b0;
  assign unused_bits = ^{syscr, tmo, ipra[7], ipra[3], iprb[7], iprb[3],
                         iprc[7], iprc[3], iprd[7], iprd[3]};
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = REQ;
          vec_d   = win_vec;
          lvl_d   = win_lvl;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SERVICE;
        end else if (!cand[vec_q]) begin
          state_d = IDLE;
          vec_d   = '0;
          lvl_d   = '0;
        end else if (win_valid && (win_lvl > lvl_q)) begin
          vec_d = win_vec;
          lvl_d = win_lvl;
        end
      end
      SERVICE: begin
        // Done has priority over a coincident expiry.
        if (irq_done || expire) begin
          state_d = IDLE;
          vec_d   = '0;
          lvl_d   = '0;
          err_d   = ~irq_done;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = '0;
        lvl_d   = '0;
      end
    endcase
    req_d = (state_d == REQ);
    svc_d = (state_d == SERVICE);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      lvl_q   <= '0;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      lvl_q   <= lvl_d;
      req_q   <= req_d;
      svc_q   <= svc_d;
      err_q   <= err_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vec    = vec_q;
  assign irq_lvl    = lvl_q;
  assign in_service = svc_q;
  assign tmo_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_irq_arbiter : table vectors plus handshake/timeout/reset sequences |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_irq_arbiter;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic [7:0] isra, isrb, iera, ierb, ipra, iprb, iprc, iprd, syscr, tmo;
  logic       irq_ack, irq_done;
  logic       irq_req, in_service, tmo_err;
  logic [3:0] irq_vec;
  logic [2:0] irq_lvl;

  always #5 pclk = ~pclk;

  irq_arbiter dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .isra       (isra),
    .isrb       (isrb),
    .iera       (iera),
    .ierb       (ierb),
    .ipra       (ipra),
    .iprb       (iprb),
    .iprc       (iprc),
    .iprd       (iprd),
    .syscr      (syscr),
    .tmo        (tmo),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .irq_lvl    (irq_lvl),
    .in_service (in_service),
    .tmo_err    (tmo_err)
  );

  typedef struct {
    logic       req, svc, err, chk_vl;
    logic [3:0] vec;
    logic [2:0] lvl;
  } exp_t;

  typedef struct {
    logic [7:0] isra, isrb, iera, ierb, ipra, iprb, iprc, iprd;
    logic       req;
    logic [3:0] vec;
    logic [2:0] lvl;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input logic req, input logic svc, input logic err,
                      input logic chk_vl, input logic [3:0] vec, input logic [2:0] lvl);
    exp_t e;
    e.req = req; e.svc = svc; e.err = err; e.chk_vl = chk_vl; e.vec = vec; e.lvl = lvl;
    sb.push_back(e);
  endtask

  task automatic compare(input string nm);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if (irq_req !== e.req || in_service !== e.svc || tmo_err !== e.err ||
          (e.chk_vl && (irq_vec !== e.vec || irq_lvl !== e.lvl))) begin
        n_bad++;
        $display("FAIL %s: got req=%b svc=%b err=%b vec=%0d lvl=%0d, expected req=%b svc=%b err=%b vec=%0d lvl=%0d (vec/lvl checked=%b)",
                 nm, irq_req, in_service, tmo_err, irq_vec, irq_lvl,
                 e.req, e.svc, e.err, e.vec, e.lvl, e.chk_vl);
      end
    end
  endtask

  // Expectation is queued when the stimulus is applied, checked one edge later.
  task automatic expect_next(input string nm, input logic req, input logic svc, input logic err,
                             input logic chk_vl, input logic [3:0] vec, input logic [2:0] lvl);
    push(req, svc, err, chk_vl, vec, lvl);
    @(negedge pclk);
    compare(nm);
  endtask

  task automatic clear_inputs();
    isra = '0; isrb = '0; iera = '0; ierb = '0;
    ipra = '0; iprb = '0; iprc = '0; iprd = '0;
    syscr = '0; tmo = '0;
  endtask

  task automatic req_src0_lvl5();
    ipra = 8'h05; iera = 8'h01; isra = 8'h01;
    expect_next("req_src0", 1, 0, 0, 1, 4'd0, 3'd5);
  endtask

  initial begin
    //          isra   isrb   iera   ierb   ipra   iprb   iprc   iprd   req vec    lvl
    tbl[0] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 1, 4'd0,  3'd5};
    tbl[1] = '{8'h0C, 8'h00, 8'h0C, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 1, 4'd2,  3'd3};
    tbl[2] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'd0,  3'd0};
    tbl[3] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 0, 4'd0,  3'd0};
    tbl[4] = '{8'h00, 8'hC0, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h70, 1, 4'd14, 3'd7};
    tbl[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12, 8'h40, 8'h00, 8'h00, 1, 4'd6,  3'd4};
    tbl[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h07, 8'h00, 8'h07, 8'h00, 1, 4'd0,  3'd7};
    tbl[7] = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h30, 1, 4'd15, 3'd3};
    tbl[8] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 1, 4'd3,  3'd6};
    tbl[9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h11, 8'h71, 8'h11, 1, 4'd10, 3'd7};

    clear_inputs();
    irq_ack = 1'b0; irq_done = 1'b0;
    repeat (2) @(negedge pclk);
    push(0, 0, 0, 1, 4'd0, 3'd0);
    compare("reset");
    preset_n = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 10; i++) begin
      isra = tbl[i].isra; isrb = tbl[i].isrb; iera = tbl[i].iera; ierb = tbl[i].ierb;
      ipra = tbl[i].ipra; iprb = tbl[i].iprb; iprc = tbl[i].iprc; iprd = tbl[i].iprd;
      expect_next($sformatf("vec%0d", i), tbl[i].req, 0, 0, tbl[i].req, tbl[i].vec, tbl[i].lvl);
      clear_inputs();
      expect_next($sformatf("vec%0d_idle", i), 0, 0, 0, 0, 4'd0, 3'd0);
    end

    // Handshake: ack in IDLE ignored, ack/done latency, re-request, done in REQ ignored
    ipra = 8'h05; iera = 8'h01; isra = 8'h01; irq_ack = 1'b1;
    expect_next("ack_in_idle_ignored", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    expect_next("req_hold", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b1;
    expect_next("ack", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    repeat (3) expect_next("service_hold", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b1;
    expect_next("done", 0, 0, 0, 0, 4'd0, 3'd0);
    irq_done = 1'b0;
    expect_next("rereq_after_done", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b1;
    expect_next("done_in_req_ignored", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b0;
    isra = 8'h00;
    expect_next("withdraw_clear", 0, 0, 0, 0, 4'd0, 3'd0);

    // Upgrade only on strictly higher level; withdraw on disable; ack beats withdraw
    clear_inputs();
    ipra = 8'h02; iera = 8'h01; isra = 8'h01;
    expect_next("upg_base", 1, 0, 0, 1, 4'd0, 3'd2);
    isra = 8'h03; iera = 8'h03;
    expect_next("equal_no_upgrade", 1, 0, 0, 1, 4'd0, 3'd2);
    iprc = 8'h06; ierb = 8'h02; isrb = 8'h02;
    expect_next("upgrade", 1, 0, 0, 1, 4'd9, 3'd6);
    ierb = 8'h00;
    expect_next("withdraw_disable", 0, 0, 0, 0, 4'd0, 3'd0);
    expect_next("rearbitrate", 1, 0, 0, 1, 4'd0, 3'd2);
    isra = 8'h00; iera = 8'h00; irq_ack = 1'b1;
    expect_next("ack_beats_withdraw", 0, 1, 0, 1, 4'd0, 3'd2);
    irq_ack = 1'b0;
    irq_done = 1'b1;
    expect_next("done2", 0, 0, 0, 0, 4'd0, 3'd0);
    irq_done = 1'b0;
    expect_next("idle_stays", 0, 0, 0, 0, 4'd0, 3'd0);

`ifdef IRQ_ARB_TMO_EN
    // tmo=4: four SERVICE cycles then a one-cycle tmo_err
    clear_inputs();
    syscr = 8'h01; tmo = 8'd4;
    req_src0_lvl5();
    irq_ack = 1'b1; isra = 8'h00;
    expect_next("tmo_svc1", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    repeat (3) expect_next("tmo_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    expect_next("tmo_err", 0, 0, 1, 0, 4'd0, 3'd0);
    expect_next("tmo_err_pulse_end", 0, 0, 0, 0, 4'd0, 3'd0);

    // done coinciding with expiry suppresses tmo_err
    isra = 8'h01;
    expect_next("tmo2_req", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b1; isra = 8'h00;
    expect_next("tmo2_svc1", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    repeat (3) expect_next("tmo2_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b1;
    expect_next("done_at_expiry", 0, 0, 0, 0, 4'd0, 3'd0);
    irq_done = 1'b0;
    expect_next("done_at_expiry_no_err", 0, 0, 0, 0, 4'd0, 3'd0);

    // tmo=1: a single SERVICE cycle
    tmo = 8'd1; isra = 8'h01;
    expect_next("tmo1_req", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b1; isra = 8'h00;
    expect_next("tmo1_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    expect_next("tmo1_err", 0, 0, 1, 0, 4'd0, 3'd0);

    // runtime enable off: no deadline
    syscr = 8'h00; tmo = 8'd4; isra = 8'h01;
    expect_next("tmo_off_req", 1, 0, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b1; isra = 8'h00;
    expect_next("tmo_off_ack", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    repeat (6) expect_next("tmo_off_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b1;
    expect_next("tmo_off_done", 0, 0, 0, 0, 4'd0, 3'd0);
    irq_done = 1'b0;
`else
    // feature absent: SERVICE is left only by irq_done
    clear_inputs();
    syscr = 8'h01; tmo = 8'd4;
    req_src0_lvl5();
    irq_ack = 1'b1; isra = 8'h00;
    expect_next("notmo_ack", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    repeat (6) expect_next("notmo_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_done = 1'b1;
    expect_next("notmo_done", 0, 0, 0, 0, 4'd0, 3'd0);
    irq_done = 1'b0;
`endif

    // Asynchronous reset in SERVICE, then the still-pending source re-requests
    clear_inputs();
    req_src0_lvl5();
    irq_ack = 1'b1;
    expect_next("rst_svc", 0, 1, 0, 1, 4'd0, 3'd5);
    irq_ack = 1'b0;
    #2 preset_n = 1'b0;
    #1;
    push(0, 0, 0, 1, 4'd0, 3'd0);
    compare("async_reset");
    @(negedge pclk);
    push(0, 0, 0, 1, 4'd0, 3'd0);
    compare("reset_held");
    preset_n = 1'b1;
    expect_next("post_reset_rereq", 1, 0, 0, 1, 4'd0, 3'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
